// File: rtl/rob_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rob_pkg : shared types, default sizes and wrap-distance helper for rob_nway
// Rev 1.0
// ----------------------------------------------------------------------------
package rob_pkg;

  localparam int c_num_rob = 32;
  localparam int c_width   = 2;
  localparam int c_num_cdb = 2;
  localparam int c_pr_w    = 6;
  localparam int c_arch_w  = 5;

  typedef struct packed {
    logic                valid;
    logic                complete;
    logic                halt;
    logic [c_pr_w-1:0]   T;
    logic [c_pr_w-1:0]   Told;
    logic [c_arch_w-1:0] dest;
  } ROB_ENTRY_t;

  typedef struct packed {
    logic                valid;
    logic                halt;
    logic [c_pr_w-1:0]   T;
    logic [c_pr_w-1:0]   Told;
    logic [c_arch_w-1:0] dest;
  } ROB_DISPATCH_t;

  typedef struct packed {
    logic                valid;
    logic [c_pr_w-1:0]   T;
    logic [c_pr_w-1:0]   Told;
    logic [c_arch_w-1:0] dest;
  } ROB_RETIRE_t;

  // Forward distance from a to b on a ring of n entries (n is a power of two).
  function automatic logic [31:0] rob_dist(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input int unsigned n);
    return (b - a) & (n - 32'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rob_nway_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rob_nway_if : dispatch / completion / rollback / retire bundle of rob_nway
// Rev 1.0
// ----------------------------------------------------------------------------
interface rob_nway_if import rob_pkg::*; #(
  parameter int NUM_ROB = c_num_rob,
  parameter int WIDTH   = c_width,
  parameter int NUM_CDB = c_num_cdb,
  parameter int PR_W    = c_pr_w,
  parameter int ARCH_W  = c_arch_w
) ();

  localparam int IDX_W = $clog2(NUM_ROB);

  logic [WIDTH-1:0]                dispatch_valid;
  logic [WIDTH-1:0][PR_W-1:0]      dispatch_T;
  logic [WIDTH-1:0][PR_W-1:0]      dispatch_Told;
  logic [WIDTH-1:0][ARCH_W-1:0]    dispatch_dest;
  logic [WIDTH-1:0]                dispatch_halt;
  logic                            dispatch_ready;
  logic [WIDTH-1:0][IDX_W-1:0]     dispatch_idx;

  logic [NUM_CDB-1:0]              complete_en;
  logic [NUM_CDB-1:0][IDX_W-1:0]   complete_idx;

  logic                            rollback_en;
  logic [IDX_W-1:0]                rollback_idx;

  logic [WIDTH-1:0]                retire_valid;
  logic [WIDTH-1:0][PR_W-1:0]      retire_T;
  logic [WIDTH-1:0][PR_W-1:0]      retire_Told;
  logic [WIDTH-1:0][ARCH_W-1:0]    retire_dest;
  logic                            halt_out;
  logic                            empty;
  logic                            full;

  modport master (
    output dispatch_valid, dispatch_T, dispatch_Told, dispatch_dest, dispatch_halt,
    output complete_en, complete_idx, rollback_en, rollback_idx,
    input  dispatch_ready, dispatch_idx,
    input  retire_valid, retire_T, retire_Told, retire_dest, halt_out, empty, full
  );

  modport slave (
    input  dispatch_valid, dispatch_T, dispatch_Told, dispatch_dest, dispatch_halt,
    input  complete_en, complete_idx, rollback_en, rollback_idx,
    output dispatch_ready, dispatch_idx,
    output retire_valid, retire_T, retire_Told, retire_dest, halt_out, empty, full
  );

endinterface
`default_nettype wire

// File: rtl/rob_retire_select.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rob_retire_select : in-order retire prefix over the WIDTH oldest ROB entries
// Rev 1.0
// ----------------------------------------------------------------------------
module rob_retire_select import rob_pkg::*; #(
  parameter int WIDTH = c_width,
  parameter int CNT_W = 6
) (
  input  wire logic             i_en,
  input  wire logic             i_halted,
  input  wire logic [WIDTH-1:0] i_head_valid,
  input  wire logic [WIDTH-1:0] i_head_complete,
  input  wire logic [WIDTH-1:0] i_head_halt,
  output logic      [WIDTH-1:0] o_retire_valid,
  output logic      [CNT_W-1:0] o_retire_cnt,
  output logic                  o_halt_retire
);

  logic w_run;

  // A halt may retire, but it closes the group behind it.
  always_comb begin
    w_run          = i_en & ~i_halted;
    o_retire_valid = '0;
    o_retire_cnt   = '0;
    o_halt_retire  = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      w_run             = w_run & i_head_valid[k] & i_head_complete[k];
      o_retire_valid[k] = w_run;
      if (w_run) begin
        o_retire_cnt = o_retire_cnt + CNT_W'(1);
        if (i_head_halt[k]) o_halt_retire = 1'b1;
      end
      w_run = w_run & ~i_head_halt[k];
    end
  end

endmodule
`default_nettype wire

// File: rtl/rob_nway.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rob_nway : N-way reorder buffer with multi-port completion, rollback, halt
// Rev 1.0
// ----------------------------------------------------------------------------
module rob_nway import rob_pkg::*; #(
  parameter int NUM_ROB = c_num_rob,
  parameter int WIDTH   = c_width,
  parameter int NUM_CDB = c_num_cdb,
  parameter int PR_W    = c_pr_w,
  parameter int ARCH_W  = c_arch_w
) (
  input  wire logic   clock,
  input  wire logic   reset_n,
  input  wire logic   en,
  rob_nway_if.slave   bus
);

  localparam int IDX_W = $clog2(NUM_ROB);
  localparam int CNT_W = $clog2(NUM_ROB + 1);

  logic [IDX_W-1:0]   r_head;
  logic [IDX_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_count;
  logic [NUM_ROB-1:0] r_valid;
  logic [NUM_ROB-1:0] r_complete;
  logic [NUM_ROB-1:0] r_halt;
  logic               r_halted;
  logic [PR_W-1:0]    r_T    [NUM_ROB];
  logic [PR_W-1:0]    r_Told [NUM_ROB];
  logic [ARCH_W-1:0]  r_dest [NUM_ROB];

  logic [WIDTH-1:0][IDX_W-1:0] w_lane_idx;
  logic [WIDTH-1:0][IDX_W-1:0] w_disp_idx;
  logic [WIDTH-1:0]            w_head_valid;
  logic [WIDTH-1:0]            w_head_complete;
  logic [WIDTH-1:0]            w_head_halt;
  logic [WIDTH-1:0]            w_ret_valid;
  logic [CNT_W-1:0]            w_ret_cnt;
  logic                        w_halt_ret;
  logic [CNT_W-1:0]            w_free;
  logic                        w_ready;
  logic [CNT_W-1:0]            w_disp_cnt;
  logic                        w_rb;
  logic [IDX_W-1:0]            w_rb_dist;
  logic [IDX_W-1:0]            w_head_n;
  logic [IDX_W-1:0]            w_tail_n;
  logic [CNT_W-1:0]            w_count_n;
  logic [NUM_ROB-1:0]          w_valid_n;
  logic [NUM_ROB-1:0]          w_complete_n;
  logic [NUM_ROB-1:0]          w_halt_n;

  for (genvar k = 0; k < WIDTH; k++) begin : g_lane
    assign w_lane_idx[k]      = r_head + IDX_W'(k);
    assign w_disp_idx[k]      = r_tail + IDX_W'(k);
    assign w_head_valid[k]    = r_valid[w_lane_idx[k]];
    assign w_head_complete[k] = r_complete[w_lane_idx[k]];
    assign w_head_halt[k]     = r_halt[w_lane_idx[k]];
    assign bus.dispatch_idx[k] = w_disp_idx[k];
    assign bus.retire_T[k]     = w_ret_valid[k] ? r_T[w_lane_idx[k]]    : '0;
    assign bus.retire_Told[k]  = w_ret_valid[k] ? r_Told[w_lane_idx[k]] : '0;
    assign bus.retire_dest[k]  = w_ret_valid[k] ? r_dest[w_lane_idx[k]] : '0;
  end

  rob_retire_select #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_retire_select (
    .i_en            (en),
    .i_halted        (r_halted),
    .i_head_valid    (w_head_valid),
    .i_head_complete (w_head_complete),
    .i_head_halt     (w_head_halt),
    .o_retire_valid  (w_ret_valid),
    .o_retire_cnt    (w_ret_cnt),
    .o_halt_retire   (w_halt_ret)
  );

  // No bypass from same-cycle retire: readiness uses registered occupancy only.
  assign w_free    = CNT_W'(NUM_ROB) - r_count;
  assign w_ready   = en & ~bus.rollback_en & ~r_halted & (w_free >= CNT_W'(WIDTH));
  assign w_rb      = en & bus.rollback_en & r_valid[bus.rollback_idx];
  assign w_rb_dist = IDX_W'(rob_dist(32'(r_head), 32'(bus.rollback_idx), NUM_ROB));

  assign bus.dispatch_ready = w_ready;
  assign bus.retire_valid   = w_ret_valid;
  assign bus.halt_out       = w_halt_ret;
  assign bus.empty          = (r_count == '0);
  assign bus.full           = (r_count == CNT_W'(NUM_ROB));

  always_comb begin
    w_valid_n    = r_valid;
    w_complete_n = r_complete;
    w_halt_n     = r_halt;
    w_disp_cnt   = '0;

    for (int p = 0; p < NUM_CDB; p++) begin
      if (en && bus.complete_en[p] && r_valid[bus.complete_idx[p]])
        w_complete_n[bus.complete_idx[p]] = 1'b1;
    end

    for (int k = 0; k < WIDTH; k++) begin
      if (w_ret_valid[k]) begin
        w_valid_n[w_lane_idx[k]]    = 1'b0;
        w_complete_n[w_lane_idx[k]] = 1'b0;
        w_halt_n[w_lane_idx[k]]     = 1'b0;
      end
    end

    // Anything younger than the branch (further from head) is flushed.
    if (w_rb) begin
      for (int i = 0; i < NUM_ROB; i++) begin
        if (IDX_W'(rob_dist(32'(r_head), 32'(i), NUM_ROB)) > w_rb_dist) begin
          w_valid_n[i]    = 1'b0;
          w_complete_n[i] = 1'b0;
          w_halt_n[i]     = 1'b0;
        end
      end
    end

    if (w_ready) begin
      for (int k = 0; k < WIDTH; k++) begin
        if (bus.dispatch_valid[k]) begin
          w_valid_n[w_disp_idx[k]]    = 1'b1;
          w_complete_n[w_disp_idx[k]] = 1'b0;
          w_halt_n[w_disp_idx[k]]     = bus.dispatch_halt[k];
          w_disp_cnt                  = w_disp_cnt + CNT_W'(1);
        end
      end
    end

    w_head_n = r_head + IDX_W'(w_ret_cnt);
    if (w_rb) begin
      w_tail_n  = bus.rollback_idx + IDX_W'(1);
      w_count_n = CNT_W'(w_rb_dist) + CNT_W'(1) - w_ret_cnt;
    end else begin
      w_tail_n  = r_tail + IDX_W'(w_disp_cnt);
      w_count_n = r_count + w_disp_cnt - w_ret_cnt;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_valid    <= '0;
      r_complete <= '0;
      r_halt     <= '0;
      r_halted   <= 1'b0;
    end else begin
      r_head     <= w_head_n;
      r_tail     <= w_tail_n;
      r_count    <= w_count_n;
      r_valid    <= w_valid_n;
      r_complete <= w_complete_n;
      r_halt     <= w_halt_n;
      r_halted   <= r_halted | w_halt_ret;
    end
  end

  // Payload is only observed behind valid, so it carries no reset.
  always_ff @(posedge clock) begin
    for (int k = 0; k < WIDTH; k++) begin
      if (w_ready && bus.dispatch_valid[k]) begin
        r_T[w_disp_idx[k]]    <= bus.dispatch_T[k];
        r_Told[w_disp_idx[k]] <= bus.dispatch_Told[k];
        r_dest[w_disp_idx[k]] <= bus.dispatch_dest[k];
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/rob_nway.md
# rob_nway

Parametrised N-way reorder buffer, successor to the single-issue ROB. Accepts up to `WIDTH` renamed instructions per cycle from dispatch, takes completion marks from `NUM_CDB` CDB ports, and retires up to `WIDTH` oldest completed instructions per cycle to the architectural map table and freelist. Supports branch rollback and halt. Sits between rename/dispatch and the arch map/freelist.

## Interface
- `NUM_ROB`, 32: entries; power of two, at least `2*WIDTH`.
- `WIDTH`, 2: dispatch and retire lanes.
- `NUM_CDB`, 2: completion ports.
- `PR_W`, 6: physical register index width.
- `ARCH_W`, 5: architectural register index width.
- `IDX_W = $clog2(NUM_ROB)`, `CNT_W = $clog2(NUM_ROB+1)`: derived, not overridable.

Ports:
- `clock`  in  1  single clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  global enable; when 0, all state holds.
- `dispatch_valid`  in  WIDTH  lane valid; lanes packed from lane 0.
- `dispatch_T`, `dispatch_Told`  in  WIDTH×PR_W  new and old physical tags.
- `dispatch_dest`  in  WIDTH×ARCH_W  arch destination.
- `dispatch_halt`  in  WIDTH  lane is a halt.
- `dispatch_ready`  out  1  ROB can accept a full `WIDTH` group this cycle.
- `dispatch_idx`  out  WIDTH×IDX_W  index assigned to each lane, `tail+k`.
- `complete_en`  in  NUM_CDB  completion strobe.
- `complete_idx`  in  NUM_CDB×IDX_W  completing entry.
- `rollback_en`  in  1  mispredict.
- `rollback_idx`  in  IDX_W  branch entry; it survives, younger entries are flushed.
- `retire_valid`  out  WIDTH  lane retires this cycle; packed prefix.
- `retire_T`, `retire_Told`  out  WIDTH×PR_W  to arch map and freelist.
- `retire_dest`  out  WIDTH×ARCH_W  to arch map.
- `halt_out`  out  1  a halt entry retires this cycle.
- `empty`, `full`  out  1  occupancy flags.

## Operation
- State: `head`, `tail` (IDX_W, wrap mod NUM_ROB), `count` (CNT_W), per-entry {valid, complete, halt, T, Told, dest}, and a sticky `halted` flag.
- Dispatch:
  - `dispatch_ready = en & !rollback_en & !halted & (NUM_ROB - count >= WIDTH)`.
  - When ready, lanes with `dispatch_valid` write at `tail+k` with valid=1, complete=0.
  - `tail` advances by popcount(`dispatch_valid`).
  - Allocation is all-or-nothing; `dispatch_valid` is ignored when not ready.
- Completion:
  - Each `complete_en[p]` sets complete on `complete_idx[p]` only if that entry is valid.
  - Duplicate indices across ports are harmless.
- Retire:
  - Lane k is valid iff entries `head..head+k` are all valid and complete and none of `head..head+k-1` is a halt.
  - A halt retires as the last lane; `halt_out=1` and `halted` is set, stopping all further retire and dispatch until reset.
  - Retired entries are cleared to valid=0; `head` advances by the retire count.
  - Retire outputs are combinational from registered state and are gated by `en`.
- Rollback:
  - Applies only if `rollback_en` and entry `rollback_idx` is valid; otherwise it is ignored.
  - Invalidates entries strictly between `rollback_idx` and `tail` (wrap-aware).
  - Sets `tail = rollback_idx+1`.
  - Sets `count = ((rollback_idx-head) mod NUM_ROB) + 1 - retired`.
  - Rollback beats dispatch in the same cycle; retire of older entries proceeds in the same cycle.
- Count: `count_next = count + dispatched - retired`, except on rollback as above.
- `empty = (count==0)`; `full = (count==NUM_ROB)`.

## Timing
- Reset (asynchronous assert, synchronous-safe release) gives:
  - head=tail=count=0, all entries valid=complete=halt=0, halted=0.
  - Outputs: `retire_valid=0`, `halt_out=0`, `empty=1`, `full=0`, `dispatch_idx[k]=k`, `dispatch_ready=en&!rollback_en`.
- Dispatch is written at the edge; an entry is complete-eligible from the next cycle.
- Completion to retire: minimum 1 cycle (completion at edge N, retire during cycle N+1).
- Dispatch to retire: minimum 2 cycles.
- Full ROB with a simultaneous `WIDTH` retire: `dispatch_ready` is still 0 that cycle (no bypass).
- Wrap-around: indices wrap mod NUM_ROB; a group may straddle index `NUM_ROB-1 → 0`.
- Reset asserted mid-operation discards all entries immediately.

## Structure
- `rob_pkg` holds:
  - `ROB_ENTRY_t`, `ROB_DISPATCH_t`, `ROB_RETIRE_t` typedefs.
  - Default parameter constants.
  - Wrap-distance function `rob_dist(a,b)`.
- Sub-module `rob_retire_select`: combinational prefix finder over the `WIDTH` head entries, producing `retire_valid` and the retire count.

## Test plan
- Reset with `en=1`: `empty=1`, `dispatch_ready=1`, `dispatch_idx={1,0}`; all retire outputs 0.
- Dispatch 16 groups of 2 with NUM_ROB=32: `full=1`, `dispatch_ready=0`. Complete idx 0 and 1, then next cycle: `retire_valid=2'b11` with lane-0 `retire_Told` equal to the idx-0 Told.
- Out-of-order completion: complete idx 1 only → no retire. Complete idx 0 → next cycle both retire.
- Wrap: head=30, tail=30, dispatch 2 groups → entries at 30, 31, 0, 1. Complete all → retire 30/31, then 0/1, and `empty=1`.
- Rollback with head=28, tail=4, `rollback_idx=30` and a simultaneous dispatch → tail=31, count=3, dispatch dropped, entries 31..3 valid=0. A later complete to idx 1 is ignored.
- Halt at entry 2 with entries 2 and 3 complete → retire lane 0 only, `halt_out=1`; thereafter `dispatch_ready=0` and `retire_valid=0` until reset.
